// File: rtl/viterbi_traceback_unit.sv
// Viterbi survivor memory and traceback engine.
// Stores per-step decision vectors, traces back from an end state and streams bits in time order.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   dec_valid, dec_bits         ACS decision vector in (bit s = state s)
//   frame_last, start_state     frame close and traceback start state
//   in_ready                    high only while collecting decisions
//   out_valid, out_bit,
//   out_last, out_ready         decoded bit stream with handshake
//   done, overflow              end-of-frame pulse; overflow = depth-limited frame
module viterbi_traceback_unit #(
  parameter int K        = 3,
  parameter int TB_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  input  logic [(2**(K-1))-1:0]   dec_bits,
  input  logic                    frame_last,
  input  logic [K-2:0]            start_state,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic                    out_bit,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    done,
  output logic                    overflow
);

  localparam int NS = 2 ** (K - 1);
  localparam int SW = K - 1;
  localparam int AW = $clog2(TB_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {
    S_WRITE,
    S_TRACE,
    S_EMIT
  } state_t;

  state_t state, state_nxt;

  logic [NS-1:0] mem [TB_DEPTH];
  logic          obuf [TB_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] nm1;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd;
  logic [SW-1:0] cur;
  logic          ovf;
  logic          beat;

  always_ff @(posedge clk) begin
    if (rst) state <= S_WRITE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    beat      = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      S_WRITE: begin
        in_ready = !rst;
        beat     = dec_valid && !rst;
        if (beat && (frame_last || wr_ptr == LAST))
          state_nxt = S_TRACE;
      end
      S_TRACE: begin
        if (idx == '0) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_bit   = obuf[rd];
        out_last  = (rd == nm1);
        if (out_ready && out_last) state_nxt = S_WRITE;
      end
      default: state_nxt = S_WRITE;
    endcase
  end

  // Storage arrays are never cleared by reset.
  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr] <= dec_bits;
    if (state == S_TRACE) obuf[idx] <= cur[SW-1];
  end

  // Frame bookkeeping that reset need not touch.
  always_ff @(posedge clk) begin
    unique case (state)
      S_WRITE: begin
        if (beat && frame_last) begin
          nm1 <= wr_ptr;
          idx <= wr_ptr;
          cur <= start_state;
          ovf <= 1'b0;
        end else if (beat && wr_ptr == LAST) begin
          nm1 <= LAST;
          idx <= LAST;
          cur <= start_state;
          ovf <= 1'b1;
        end
      end
      S_TRACE: begin
        // Predecessor drops the newest bit and appends the decision bit as the oldest one.
        cur <= {cur[SW-2:0], mem[idx][cur]};
        idx <= idx - 1'b1;
        rd  <= '0;
      end
      S_EMIT: begin
        if (out_ready && !out_last) rd <= rd + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= 1'b0;
      if (beat) wr_ptr <= wr_ptr + 1'b1;
      if (state == S_EMIT && out_ready && out_last) begin
        wr_ptr   <= '0;
        done     <= 1'b1;
        overflow <= ovf;
      end
    end
  end

endmodule
